// File: rtl/simple_ram.sv
// simple_ram: single-port synchronous RAM with a registered read port.
//
// Parameters:
//   ADDR_WIDTH - address width; the depth is 2**ADDR_WIDTH words.
//   DATA_WIDTH - word width.
//
// Ports:
//   clk  - clock; all state updates on the rising edge.
//   rst  - synchronous, active-high reset. Clears the whole array and dout.
//   we   - write enable: 1 = write din to addr, 0 = read addr.
//   addr - word address for both writes and reads.
//   din  - write data.
//   dout - registered read data. It is updated on every access and holds
//          between edges. A write also returns din on dout (write-first).

module simple_ram #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    // A write bypasses the array so dout shows the new data on the same edge.
    always_comb begin
        dout_d = mem_q[addr];
        if (we) begin
            dout_d = din;
        end
    end

    // The reset loop clears every word, so this array maps to registers rather
    // than a memory macro. At this size that is the intended implementation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_simple_ram.sv
// tb_simple_ram: scoreboard bench for simple_ram.
// The driver issues one access per cycle. When an access is checked, the
// driver pushes its expected dout onto a queue. The vld flag follows the DUT's
// one-cycle latency. The monitor pops and compares on the falling edge after
// the capturing rising edge.

module tb_simple_ram;

    logic       clk;
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    typedef struct {
        logic [7:0] exp;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    logic issue_chk;
    logic vld;
    int   checks;
    int   errors;
    int   next_id;

    simple_ram #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .addr(addr),
        .din (din),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Marks the cycle whose dout belongs to a checked access.
    always @(posedge clk) vld <= issue_chk;

    // Monitor: runs once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (vld === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_output: dout=%02h, no expected value queued", dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (dout !== e.exp) begin
                    errors = errors + 1;
                    $display("FAIL check_%0d: dout=%02h expected=%02h", e.id, dout, e.exp);
                end
            end
        end
    end

    // One access per cycle. When chk is set, dout after this edge must equal e.
    task automatic op(input bit r, input bit w, input int a, input int d, input bit chk,
                      input logic [7:0] e);
        exp_t item;
        @(posedge clk);
        #1;
        rst       = r;
        we        = w;
        addr      = a[3:0];
        din       = d[7:0];
        issue_chk = chk;
        if (chk) begin
            item.exp = e;
            item.id  = next_id;
            next_id  = next_id + 1;
            exp_q.push_back(item);
        end
    endtask

    task automatic wr(input int a, input int d);
        op(1'b0, 1'b1, a, d, 1'b1, d[7:0]);
    endtask

    task automatic rd(input int a, input logic [7:0] e);
        op(1'b0, 1'b0, a, 0, 1'b1, e);
    endtask

    initial begin
        int wait_cycles;
        checks    = 0;
        errors    = 0;
        next_id   = 0;
        vld       = 1'b0;
        issue_chk = 1'b0;
        rst       = 1'b1;
        we        = 1'b0;
        addr      = '0;
        din       = '0;

        // Reset clear. This reset edge is checked too.
        op(1'b1, 1'b0, 0, 0, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) rd(i, 8'h00);

        // Basic write/read. Each write also shows din on dout (write-first).
        wr(4, 8'hAA);
        wr(7, 8'h55);
        rd(4, 8'hAA);
        rd(7, 8'h55);

        // Hold: repeated reads leave dout unchanged and do not modify the array.
        for (int i = 0; i < 5; i++) rd(7, 8'h55);
        rd(4, 8'hAA);

        // Write-first, then read back on the next cycle.
        wr(2, 8'h3C);
        rd(2, 8'h3C);

        // Isolation and overwrite.
        for (int i = 0; i < 16; i++) wr(i, i * 8'h11);
        wr(15, 8'hF0);
        for (int i = 0; i < 15; i++) rd(i, 8'(i * 8'h11));
        rd(15, 8'hF0);

        // Reset has priority over a write. Prior contents are discarded.
        op(1'b1, 1'b1, 5, 8'h77, 1'b1, 8'h00);
        rd(5, 8'h00);
        rd(15, 8'h00);
        rd(3, 8'h00);

        // Reset held for several cycles. A write then follows the release directly.
        wr(9, 8'hC3);
        op(1'b1, 1'b0, 9, 0, 1'b1, 8'h00);
        op(1'b1, 1'b0, 9, 0, 1'b1, 8'h00);
        op(1'b1, 1'b1, 9, 8'h12, 1'b1, 8'h00);
        wr(1, 8'h5A);
        rd(9, 8'h00);
        rd(1, 8'h5A);

        // Drain the scoreboard within a bounded number of cycles.
        @(posedge clk);
        #1;
        issue_chk = 1'b0;
        we        = 1'b0;
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
